// File: rtl/twiddle_addr_seq.sv
// Twiddle-factor address sequencer: issues (r*c*stride) mod N for an R x C
// loop nest using only adds and conditional subtracts, with valid/ready output.
module twiddle_addr_seq #(
    parameter int unsigned N      = 108,
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned TW_LAT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] stride,
    input  logic [7:0]        rows,
    input  logic [7:0]        cols,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_valid,
    output logic              tw_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned SUM_W = ADDR_W + 1;
    localparam logic [SUM_W-1:0] N_S = SUM_W'(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [7:0]        rows_q, rows_d;
    logic [7:0]        cols_q, cols_d;
    logic [7:0]        r_q, r_d;
    logic [7:0]        c_q, c_d;
    logic [ADDR_W-1:0] row_step_q, row_step_d;
    logic [ADDR_W-1:0] acc_q, acc_d;
    logic              addr_valid_q, addr_valid_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              hs;
    logic              last_col;
    logic              last;
    logic              legal;

    // (a + b) mod N for a, b < N: one widened add and one conditional subtract
    function automatic logic [ADDR_W-1:0] mod_add(input logic [ADDR_W-1:0] a,
                                                  input logic [ADDR_W-1:0] b);
        logic [SUM_W-1:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= N_S) begin
            s = s - N_S;
        end
        return s[ADDR_W-1:0];
    endfunction

    assign hs       = addr_valid_q & out_ready;
    assign last_col = (c_q == 8'(cols_q - 8'd1));
    assign last     = last_col && (r_q == 8'(rows_q - 8'd1));
    assign legal    = ({1'b0, stride} < N_S) && (rows != 8'd0) && (cols != 8'd0);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            stride_q     <= '0;
            rows_q       <= '0;
            cols_q       <= '0;
            r_q          <= '0;
            c_q          <= '0;
            row_step_q   <= '0;
            acc_q        <= '0;
            addr_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            stride_q     <= stride_d;
            rows_q       <= rows_d;
            cols_q       <= cols_d;
            r_q          <= r_d;
            c_q          <= c_d;
            row_step_q   <= row_step_d;
            acc_q        <= acc_d;
            addr_valid_q <= addr_valid_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    // Next-state, loop counters and incremental address update
    always_comb begin
        state_d    = state_q;
        stride_d   = stride_q;
        rows_d     = rows_q;
        cols_d     = cols_q;
        r_d        = r_q;
        c_d        = c_q;
        row_step_d = row_step_q;
        acc_d      = acc_q;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (legal) begin
                        stride_d   = stride;
                        rows_d     = rows;
                        cols_d     = cols;
                        r_d        = '0;
                        c_d        = '0;
                        row_step_d = '0;
                        acc_d      = '0;
                        state_d    = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (hs) begin
                    if (last) begin
                        state_d = (TW_LAT == 0) ? IDLE : DRAIN;
                    end else if (last_col) begin
                        c_d        = '0;
                        r_d        = 8'(r_q + 8'd1);
                        row_step_d = mod_add(row_step_q, stride_q);
                        acc_d      = '0;
                    end else begin
                        c_d   = 8'(c_q + 8'd1);
                        acc_d = mod_add(acc_q, row_step_q);
                    end
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        addr_valid_d = (state_d == RUN);
        busy_d       = (state_d != IDLE);
    end

    assign addr       = acc_q;
    assign addr_valid = addr_valid_q;
    assign busy       = busy_q;
    assign err        = err_q;

    // Table-read valid tracks the handshake through the table latency
    if (TW_LAT == 0) begin : g_lat0
        assign tw_valid = hs;
        assign done     = hs & last;
    end else begin : g_lat1
        logic tw_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tw_q <= 1'b0;
            end else begin
                tw_q <= hs;
            end
        end
        assign tw_valid = tw_q;
        assign done     = tw_q & (state_q == DRAIN);
    end

endmodule

// File: tb/tb_twiddle_addr_seq.sv
// Bench for twiddle_addr_seq: a TW_LAT=0 and a TW_LAT=1 instance share stimulus
// and are checked cycle by cycle against a list of (r*c*stride) mod N addresses.
module tb_twiddle_addr_seq;

    localparam int NN = 108;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [10:0] stride;
    logic [7:0]  rows;
    logic [7:0]  cols;
    logic        out_ready;

    logic [10:0] addr0, addr1;
    logic        av0, tw0, busy0, done0, err0;
    logic        av1, tw1, busy1, done1, err1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    twiddle_addr_seq #(.N(108), .ADDR_W(11), .TW_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .stride(stride), .rows(rows),
        .cols(cols), .out_ready(out_ready), .addr(addr0), .addr_valid(av0),
        .tw_valid(tw0), .busy(busy0), .done(done0), .err(err0)
    );

    twiddle_addr_seq #(.N(108), .ADDR_W(11), .TW_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stride(stride), .rows(rows),
        .cols(cols), .out_ready(out_ready), .addr(addr1), .addr_valid(av1),
        .tw_valid(tw1), .busy(busy1), .done(done1), .err(err1)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        logic [15:0] obs;
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
        stride = 11'd9; rows = 8'd2; cols = 8'd3;
        repeat (3) @(negedge clk);
        #1;
        obs = {addr0, av0, tw0, busy0, done0, err0};
        total_cnt++;
        if (obs !== 16'd0) $display("FAIL reset_lat0 got=%h exp=0", obs);
        else pass_cnt++;
        obs = {addr1, av1, tw1, busy1, done1, err1};
        total_cnt++;
        if (obs !== 16'd0) $display("FAIL reset_lat1 got=%h exp=0", obs);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Runs one sequence; bp_at/bp_len stall out_ready at a given address,
    // rnd_ready randomises out_ready, mid_start pokes start and inputs while busy.
    task automatic test_sequence(input int s, input int r, input int c, input int bp_at,
                                 input int bp_len, input bit rnd_ready, input bit mid_start);
        int   exp_q[$];
        int   total, idx, bp;
        bit   hs, lastc, prev_hs, prev_last, fin0, fin1, post;
        logic [4:0] obs, expv;
        for (int rr = 0; rr < r; rr++)
            for (int cc = 0; cc < c; cc++)
                exp_q.push_back((rr * cc * s) % NN);
        total = r * c;
        idx = 0; bp = 0; prev_hs = 0; prev_last = 0; fin0 = 0; fin1 = 0; post = 0;
        @(negedge clk);
        stride = 11'(s); rows = 8'(r); cols = 8'(c); start = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (rnd_ready) out_ready = ($urandom_range(0, 2) != 0);
            else if (idx == bp_at && bp < bp_len) begin out_ready = 1'b0; bp++; end
            else out_ready = 1'b1;
            #1;
            hs    = (idx < total) && out_ready;
            lastc = hs && (idx == total - 1);
            obs  = {av0, tw0, done0, busy0, err0};
            expv = {(idx < total), hs, lastc, !fin0, 1'b0};
            total_cnt++;
            if (obs !== expv)
                $display("FAIL seq_ctl0 s=%0d r=%0d c=%0d idx=%0d got=%b exp=%b", s, r, c, idx, obs, expv);
            else pass_cnt++;
            obs  = {av1, tw1, done1, busy1, err1};
            expv = {(idx < total), prev_hs, prev_last, !fin1, 1'b0};
            total_cnt++;
            if (obs !== expv)
                $display("FAIL seq_ctl1 s=%0d r=%0d c=%0d idx=%0d got=%b exp=%b", s, r, c, idx, obs, expv);
            else pass_cnt++;
            if (idx < total) begin
                total_cnt++;
                if (addr0 !== 11'(exp_q[idx]))
                    $display("FAIL seq_addr0 s=%0d idx=%0d got=%0d exp=%0d", s, idx, addr0, exp_q[idx]);
                else pass_cnt++;
                total_cnt++;
                if (addr1 !== 11'(exp_q[idx]))
                    $display("FAIL seq_addr1 s=%0d idx=%0d got=%0d exp=%0d", s, idx, addr1, exp_q[idx]);
                else pass_cnt++;
            end
            fin0 = fin0 | lastc;
            fin1 = fin1 | prev_last;
            prev_hs = hs;
            prev_last = lastc;
            if (hs) idx++;
            if (mid_start) begin
                stride = 11'($urandom);
                rows   = 8'($urandom);
                cols   = 8'($urandom);
                start  = (idx < total) && ($urandom_range(0, 3) == 0);
            end
            if (post) break;
            if (fin0 && fin1) post = 1;
        end
        start = 1'b0;
        out_ready = 1'b1;
        total_cnt++;
        if (!post) $display("FAIL seq_timeout s=%0d r=%0d c=%0d handshakes=%0d exp=%0d", s, r, c, idx, total);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        test_sequence(9, 2, 3, -1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_mod_wrap();
        test_sequence(9, 2, 13, -1, 0, 1'b0, 1'b0);
        test_sequence(53, 3, 3, -1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        test_sequence(9, 2, 3, 4, 3, 1'b0, 1'b0);
        test_sequence(31, 3, 4, 0, 2, 1'b0, 1'b0);
    endtask

    task automatic test_illegal();
        int cases [4][3] = '{'{108, 2, 3}, '{9, 0, 3}, '{9, 2, 0}, '{2047, 1, 1}};
        logic [3:0] obs;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            stride = 11'(cases[k][0]); rows = 8'(cases[k][1]); cols = 8'(cases[k][2]);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            #1;
            obs = {err0, av0, busy0, done0};
            total_cnt++;
            if (obs !== 4'b1000) $display("FAIL illegal_lat0 case=%0d got=%b exp=1000", k, obs);
            else pass_cnt++;
            obs = {err1, av1, busy1, done1};
            total_cnt++;
            if (obs !== 4'b1000) $display("FAIL illegal_lat1 case=%0d got=%b exp=1000", k, obs);
            else pass_cnt++;
            @(negedge clk);
            #1;
            obs = {err0 | err1, av0 | av1, busy0 | busy1, done0 | done1};
            total_cnt++;
            if (obs !== 4'b0000) $display("FAIL illegal_after case=%0d got=%b exp=0000", k, obs);
            else pass_cnt++;
        end
    endtask

    task automatic test_busy_start();
        test_sequence(9, 2, 3, -1, 0, 1'b0, 1'b1);
        test_sequence(107, 4, 5, -1, 0, 1'b1, 1'b1);
    endtask

    task automatic test_boundary();
        test_sequence(107, 1, 1, -1, 0, 1'b0, 1'b0);
        test_sequence(0, 3, 4, -1, 0, 1'b0, 1'b0);
        test_sequence(1, 1, 200, -1, 0, 1'b0, 1'b0);
        test_sequence(5, 255, 1, -1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 10; k++) begin
            test_sequence(int'($urandom_range(0, NN - 1)), int'($urandom_range(1, 7)),
                          int'($urandom_range(1, 20)), int'($urandom_range(0, 10)),
                          int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)),
                          bit'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] obs;
        bit saw_done;
        saw_done = 0;
        @(negedge clk);
        stride = 11'd9; rows = 8'd2; cols = 8'd3; start = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        total_cnt++;
        if ({av0, addr0} !== {1'b1, 11'd0}) $display("FAIL rstmid_third av=%b addr=%0d exp av=1 addr=0", av0, addr0);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        obs = {addr0, av0, tw0, busy0, done0, err0};
        total_cnt++;
        if (obs !== 16'd0) $display("FAIL rstmid_async0 got=%h exp=0", obs);
        else pass_cnt++;
        obs = {addr1, av1, tw1, busy1, done1, err1};
        total_cnt++;
        if (obs !== 16'd0) $display("FAIL rstmid_async1 got=%h exp=0", obs);
        else pass_cnt++;
        repeat (2) begin
            @(negedge clk);
            saw_done = saw_done | done0 | done1 | tw1;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            saw_done = saw_done | done0 | done1 | busy0 | busy1;
        end
        total_cnt++;
        if (saw_done) $display("FAIL rstmid_nodone got=1 exp=0");
        else pass_cnt++;
        test_sequence(9, 2, 3, -1, 0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mod_wrap();
        test_backpressure();
        test_illegal();
        test_busy_start();
        test_boundary();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
